// File: rtl/manchester_pkg.sv
// Shared encodings and constants for the Manchester nibble decoder.
package manchester_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Chip pairs, first-received chip in bit 1
    localparam logic [1:0] PAIR_ONE  = 2'b10;
    localparam logic [1:0] PAIR_ZERO = 2'b01;

    localparam int PAIRS_PER_FRAME = 4;

    // Result of decoding one chip pair
    typedef struct packed {
        logic bit_val;
        logic viol;
    } pair_dec_t;

    // Insert one decoded bit so that after a full frame the first bit sits
    // at [3] (msb_first) or at [0] (lsb first).
    function automatic logic [3:0] shift_in(input logic [3:0] sr,
                                            input logic       b,
                                            input logic       msb_first);
        if (msb_first) begin
            return {sr[2:0], b};
        end
        return {b, sr[3:1]};
    endfunction

endpackage

// File: rtl/mdec_pair.sv
// Combinational Manchester chip-pair decoder: "10" -> 1, "01" -> 0,
// "00"/"11" -> violation (reported bit is 0).
module mdec_pair
    import manchester_pkg::*;
(
    input  logic [1:0] i_pair,
    output pair_dec_t  o_dec
);

    // Pair lookup
    always_comb begin
        o_dec = '{bit_val: 1'b0, viol: 1'b1};
        case (i_pair)
            PAIR_ONE:  o_dec = '{bit_val: 1'b1, viol: 1'b0};
            PAIR_ZERO: o_dec = '{bit_val: 1'b0, viol: 1'b0};
            default:   o_dec = '{bit_val: 1'b0, viol: 1'b1};
        endcase
    end

endmodule

// File: rtl/manchester_nibble_decoder.sv
// Manchester nibble decoder: collects 8 accepted chips (4 pairs) after a
// frame_start pulse and reports the decoded nibble plus a violation flag.
//
//   state  | meaning
//   IDLE   | no frame open, chips ignored
//   FIRST  | awaiting first chip of a pair
//   SECOND | awaiting second chip of a pair
//   DONE   | one-cycle result state (data_valid high)
//
// A mid-frame gap of TIMEOUT cycles without an accepted chip aborts the
// frame with a one-cycle timeout pulse. frame_start always wins.
module manchester_nibble_decoder
    import manchester_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       chip_valid,
    input  logic       chip_in,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       code_err,
    output logic       timeout,
    output logic       busy
);

    localparam logic [7:0] GAP_LAST  = 8'(TIMEOUT - 1);
    localparam logic [1:0] LAST_PAIR = 2'(PAIRS_PER_FRAME - 1);
    localparam logic       ORDER_MSB = (MSB_FIRST != 0);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_first_chip;
    logic [3:0] r_shift;
    logic [1:0] r_pairs;
    logic       r_err;
    logic [7:0] r_gap;
    logic [3:0] r_data_out;
    logic       r_data_valid;
    logic       r_code_err;
    logic       r_timeout;

    logic       w_in_frame;
    logic       w_accept;
    logic       w_pair_done;
    logic       w_frame_done;
    logic       w_expire;
    logic [1:0] w_pair;
    pair_dec_t  w_dec;
    logic [3:0] w_shift_next;

    assign w_pair = {r_first_chip, chip_in};

    mdec_pair u_pair (
        .i_pair (w_pair),
        .o_dec  (w_dec)
    );

    assign w_in_frame   = (r_state == ST_FIRST) || (r_state == ST_SECOND);
    // A chip coinciding with frame_start is discarded.
    assign w_accept     = w_in_frame && chip_valid && !frame_start;
    assign w_pair_done  = (r_state == ST_SECOND) && w_accept;
    assign w_frame_done = w_pair_done && (r_pairs == LAST_PAIR);
    assign w_expire     = w_in_frame && !frame_start && !chip_valid
                          && (r_gap == GAP_LAST);
    assign w_shift_next = shift_in(r_shift, w_dec.bit_val, ORDER_MSB);

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        if (frame_start) begin
            w_state_next = ST_FIRST;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_IDLE;
                ST_FIRST: begin
                    if (w_accept) begin
                        w_state_next = ST_SECOND;
                    end else if (w_expire) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_SECOND: begin
                    if (w_frame_done) begin
                        w_state_next = ST_DONE;
                    end else if (w_pair_done) begin
                        w_state_next = ST_FIRST;
                    end else if (w_expire) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_DONE: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame accumulation: held first chip, shift register, pair count, error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_first_chip <= 1'b0;
            r_shift      <= 4'h0;
            r_pairs      <= 2'd0;
            r_err        <= 1'b0;
        end else if (frame_start) begin
            r_first_chip <= 1'b0;
            r_shift      <= 4'h0;
            r_pairs      <= 2'd0;
            r_err        <= 1'b0;
        end else if (w_accept && (r_state == ST_FIRST)) begin
            r_first_chip <= chip_in;
        end else if (w_pair_done) begin
            r_shift <= w_shift_next;
            r_pairs <= r_pairs + 2'd1;
            r_err   <= r_err | w_dec.viol;
        end
    end

    // Inter-chip gap counter; only runs while a frame is open
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gap <= 8'd0;
        end else if (frame_start || w_accept || !w_in_frame || w_expire) begin
            r_gap <= 8'd0;
        end else begin
            r_gap <= r_gap + 8'd1;
        end
    end

    // Registered outputs: result capture and one-cycle pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out   <= 4'h0;
            r_data_valid <= 1'b0;
            r_code_err   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_data_valid <= w_frame_done;
            r_timeout    <= w_expire;
            if (w_frame_done) begin
                r_data_out <= w_shift_next;
                r_code_err <= r_err | w_dec.viol;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign code_err   = r_code_err;
    assign timeout    = r_timeout;
    assign busy       = w_in_frame;

endmodule

// File: tb/tb_manchester_nibble_decoder.sv
// Self-checking bench: two decoders (MSB-first and LSB-first) share stimulus
// and are compared every cycle against a chip-list reference model.
module tb_manchester_nibble_decoder;

    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, frame_start, chip_valid, chip_in;
    logic [3:0] dm_data, dl_data;
    logic dm_dv, dm_err, dm_to, dm_busy;
    logic dl_dv, dl_err, dl_to, dl_busy;

    manchester_nibble_decoder #(.TIMEOUT(TO), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .chip_valid(chip_valid), .chip_in(chip_in),
        .data_out(dm_data), .data_valid(dm_dv), .code_err(dm_err),
        .timeout(dm_to), .busy(dm_busy)
    );

    manchester_nibble_decoder #(.TIMEOUT(TO), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .chip_valid(chip_valid), .chip_in(chip_in),
        .data_out(dl_data), .data_valid(dl_dv), .code_err(dl_err),
        .timeout(dl_to), .busy(dl_busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model state
    bit       m_active = 0;
    bit       m_chips[$];
    int       m_idle = 0;
    logic [3:0] e_data_m = 4'h0, e_data_l = 4'h0;
    logic     e_dv = 0, e_err = 0, e_to = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_decode();
        bit a, b;
        e_err = 0;
        e_data_m = 4'h0;
        e_data_l = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a = m_chips[2*i];
            b = m_chips[2*i+1];
            if (a == b) e_err = 1;
            e_data_m[3-i] = (a && !b);
            e_data_l[i]   = (a && !b);
        end
    endtask

    task automatic model_update(input logic rst, input logic fs, input logic cv, input logic ci);
        e_dv = 0;
        e_to = 0;
        if (!rst) begin
            m_active = 0;
            m_chips.delete();
            m_idle = 0;
            e_data_m = 4'h0;
            e_data_l = 4'h0;
            e_err = 0;
        end else if (fs) begin
            m_active = 1;
            m_chips.delete();
            m_idle = 0;
        end else if (m_active) begin
            if (cv) begin
                m_chips.push_back(ci);
                m_idle = 0;
                if (m_chips.size() == 8) begin
                    model_decode();
                    m_active = 0;
                    e_dv = 1;
                end
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    e_to = 1;
                    m_active = 0;
                    m_idle = 0;
                end
            end
        end
    endtask

    // Per-cycle comparison of both decoders against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_data_out", dm_data, e_data_m);
            check("m_data_valid", {3'b0, dm_dv}, {3'b0, e_dv});
            check("m_code_err", {3'b0, dm_err}, {3'b0, e_err});
            check("m_timeout", {3'b0, dm_to}, {3'b0, e_to});
            check("m_busy", {3'b0, dm_busy}, {3'b0, m_active});
            check("l_data_out", dl_data, e_data_l);
            check("l_data_valid", {3'b0, dl_dv}, {3'b0, e_dv});
            check("l_code_err", {3'b0, dl_err}, {3'b0, e_err});
            check("l_timeout", {3'b0, dl_to}, {3'b0, e_to});
            check("l_busy", {3'b0, dl_busy}, {3'b0, m_active});
        end
    end

    task automatic step(input logic rst, input logic fs, input logic cv, input logic ci);
        reset = rst;
        frame_start = fs;
        chip_valid = cv;
        chip_in = ci;
        @(posedge clk);
        model_update(rst, fs, cv, ci);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic chip(input logic c);
        step(1, 0, 1, c);
    endtask

    task automatic start();
        step(1, 1, 0, 0);
    endtask

    task automatic send(input logic [7:0] seq, input int gap);
        logic [7:0] s;
        s = seq;
        for (int i = 0; i < 8; i++) begin
            chip(s[7-i]);
            if (i < 7) idle(gap);
        end
    endtask

    initial begin
        logic [7:0] seq;
        int dense;
        reset = 0;
        frame_start = 0;
        chip_valid = 0;
        chip_in = 0;
        step(0, 0, 0, 0);
        chk_en = 1;
        check("rst_data_out", dm_data, 4'h0);
        check("rst_busy", {3'b0, dm_busy}, 4'h0);
        step(0, 0, 0, 0);
        idle(2);

        // Consecutive chips 0,1,1,0,0,1,1,0
        start();
        send(8'b01100110, 0);
        check("lit_0101_dv", {3'b0, dm_dv}, 4'h1);
        check("lit_0101_data", dm_data, 4'b0101);
        check("lit_0101_err", {3'b0, dm_err}, 4'h0);
        check("model_0101", e_data_m, 4'b0101);
        idle(2);

        // Chips 1,0,... with 3 idle cycles between each
        start();
        send(8'b10101010, 3);
        check("lit_1111_data", dm_data, 4'b1111);
        check("lit_1111_dv", {3'b0, dm_dv}, 4'h1);
        idle(2);

        // Violation in pair 2
        start();
        send(8'b10110110, 0);
        check("lit_1001_data", dm_data, 4'b1001);
        check("lit_1001_err", {3'b0, dm_err}, 4'h1);
        check("model_1001_err", {3'b0, e_err}, 4'h1);
        idle(2);

        // Timeout after two pairs
        start();
        chip(1); chip(0); chip(0); chip(1);
        idle(TO - 1);
        check("lit_to_early", {3'b0, dm_to}, 4'h0);
        idle(1);
        check("lit_to_pulse", {3'b0, dm_to}, 4'h1);
        check("lit_to_busy", {3'b0, dm_busy}, 4'h0);
        check("lit_to_data", dm_data, 4'b1001);
        check("lit_to_dv", {3'b0, dm_dv}, 4'h0);
        idle(2);

        // Abort mid-pair then a full frame of zeros
        start();
        chip(1); chip(0); chip(0);
        start();
        send(8'b01010101, 0);
        check("lit_abort_data", dm_data, 4'b0000);
        check("lit_abort_dv", {3'b0, dm_dv}, 4'h1);
        idle(2);

        // Nibble 0001 sent first-bit-first; LSB-first instance reverses it
        start();
        chip(1); chip(0); chip(0);
        start();
        send(8'b01010110, 0);
        check("lit_msb_0001", dm_data, 4'b0001);
        check("lit_lsb_1000", dl_data, 4'b1000);
        check("model_lsb_1000", e_data_l, 4'b1000);
        idle(2);

        // frame_start on the cycle the gap would expire
        start();
        idle(TO - 1);
        start();
        check("lit_fs_wins_to", {3'b0, dm_to}, 4'h0);
        check("lit_fs_wins_busy", {3'b0, dm_busy}, 4'h1);
        idle(TO + 2);

        // Reset mid-frame
        start();
        chip(1); chip(0); chip(1); chip(0); chip(1);
        step(0, 0, 0, 0);
        chip(0); chip(1); chip(0);
        check("lit_rst_data", dm_data, 4'h0);
        check("lit_rst_dv", {3'b0, dm_dv}, 4'h0);
        check("lit_rst_err", {3'b0, dm_err}, 4'h0);
        check("lit_rst_to", {3'b0, dm_to}, 4'h0);
        check("lit_rst_busy", {3'b0, dm_busy}, 4'h0);
        idle(2);

        // Randomized traffic with alternating dense and sparse chip phases
        dense = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dense = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 24) == 0),
                 dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
